// File: rtl/ks_mix_i2s.sv
// Six-voice Karplus-Strong mixer with attenuation/saturation feeding a mono I2S master stream.
// Optional level meter with peak hold is built when KS_MIX_METER_EN is defined.
module ks_mix_i2s #(
  parameter int BCLK_HALF = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [15:0] voice0,
  input  logic [15:0] voice1,
  input  logic [15:0] voice2,
  input  logic [15:0] voice3,
  input  logic [15:0] voice4,
  input  logic [15:0] voice5,
  input  logic [5:0]  voice_en,
  input  logic [1:0]  att,
  input  logic        sat_clr,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        sample_tick,
  output logic        sat_flag,
  output logic [7:0]  leds_meter
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAP, S_ACC, S_SAT} state_t;

  function automatic logic is_clip(input logic signed [18:0] s);
    return (s > 19'sd32767) || (s < -19'sd32768);
  endfunction

  function automatic logic [15:0] clip16(input logic signed [18:0] s);
    if (s > 19'sd32767)       return 16'h7FFF;
    else if (s < -19'sd32768) return 16'h8000;
    else                      return s[15:0];
  endfunction

  logic [DIV_W-1:0]    div_q;
  logic                bclk_q, sdata_q, tick_q, sat_q;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [15:0]         tx_word_q, mix_q;
  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic signed [15:0]  snap_q [6];
  logic [5:0]          en_snap_q;
  logic signed [18:0]  acc_q, acc_sh, addend;
  logic                div_wrap, bclk_fall, frame_start, sdata_d;
  logic [4:0]          slot_p;
  logic [3:0]          bit_sel;

  assign div_wrap    = (div_q == DIV_LAST);
  assign bclk_fall   = div_wrap & bclk_q;
  assign frame_start = bclk_fall & (bit_cnt_q == 6'd63);
  assign bit_cnt_d   = bit_cnt_q + 6'd1;
  assign slot_p      = bit_cnt_d[4:0];
  // slot bit p carries tx_word[16-p]; (16-p) mod 16 == -p mod 16
  assign bit_sel     = 4'd0 - slot_p[3:0];
  assign sdata_d     = (slot_p != 5'd0 && slot_p <= 5'd16) ? tx_word_q[bit_sel] : 1'b0;

  assign addend = en_snap_q[idx_q] ? {{3{snap_q[idx_q][15]}}, snap_q[idx_q]} : 19'sd0;
  assign acc_sh = acc_q >>> att;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (frame_start) state_d = S_CAP;
      S_CAP: begin
        state_d = S_ACC;
        idx_d   = 3'd0;
      end
      S_ACC: begin
        if (idx_q == 3'd5) state_d = S_SAT;
        else               idx_d   = idx_q + 3'd1;
      end
      S_SAT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= 6'd63;
      sdata_q   <= 1'b0;
      tick_q    <= 1'b0;
      tx_word_q <= '0;
      mix_q     <= '0;
      sat_q     <= 1'b0;
      state_q   <= S_IDLE;
      idx_q     <= '0;
    end else begin
      div_q   <= div_wrap ? '0 : div_q + 1'b1;
      if (div_wrap) bclk_q <= ~bclk_q;
      tick_q  <= frame_start;
      if (bclk_fall) begin
        bit_cnt_q <= bit_cnt_d;
        sdata_q   <= sdata_d;
      end
      if (frame_start) tx_word_q <= mix_q;
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_SAT) mix_q <= clip16(acc_sh);
      // a clip in the same cycle as sat_clr must leave the flag set
      if (state_q == S_SAT && is_clip(acc_sh)) sat_q <= 1'b1;
      else if (sat_clr)                        sat_q <= 1'b0;
    end
  end

  // Snapshot and accumulator are pure datapath; always written in CAP before use.
  always_ff @(posedge clk_clk) begin
    if (state_q == S_CAP) begin
      snap_q[0] <= voice0;
      snap_q[1] <= voice1;
      snap_q[2] <= voice2;
      snap_q[3] <= voice3;
      snap_q[4] <= voice4;
      snap_q[5] <= voice5;
      en_snap_q <= voice_en;
      acc_q     <= 19'sd0;
    end else if (state_q == S_ACC) begin
      acc_q <= acc_q + addend;
    end
  end

  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = bit_cnt_q[5];
  assign i2s_sdata   = sdata_q;
  assign sample_tick = tick_q;
  assign sat_flag    = sat_q;

`ifdef KS_MIX_METER_EN
  logic        meter_upd_q;
  logic [7:0]  meter_q, meter_hit;
  logic [4:0]  hold_q [8];
  logic [16:0] mag;

  // |0x8000| = 32768 falls out of negating the 17-bit sign extension
  assign mag = mix_q[15] ? (17'd0 - {mix_q[15], mix_q}) : {1'b0, mix_q};

  always_comb begin
    meter_hit = '0;
    for (int k = 0; k < 8; k++) meter_hit[k] = (mag >= (17'd1 << (7 + k)));
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      meter_upd_q <= 1'b0;
      meter_q     <= '0;
      for (int k = 0; k < 8; k++) hold_q[k] <= '0;
    end else begin
      meter_upd_q <= (state_q == S_SAT);
      for (int k = 0; k < 8; k++) begin
        if (frame_start && hold_q[k] != 5'd0) hold_q[k] <= hold_q[k] - 5'd1;
        if (meter_upd_q) begin
          if (meter_hit[k]) begin
            meter_q[k] <= 1'b1;
            hold_q[k]  <= 5'd16;
          end else if (hold_q[k] == 5'd0) begin
            meter_q[k] <= 1'b0;
          end
        end
      end
    end
  end

  assign leds_meter = meter_q;
`else
  assign leds_meter = 8'h00;
`endif

endmodule

// File: tb/tb_ks_mix_i2s.sv
// Scoreboard bench for ks_mix_i2s: expected words queued at stimulus time, popped as I2S slots complete.
`timescale 1ns/1ps
module tb_ks_mix_i2s;

  localparam int BH     = 8;
  localparam int FRAME  = 128 * BH;
  localparam int NS     = 9;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [15:0] vin [6];
  logic [5:0]  voice_en;
  logic [1:0]  att;
  logic        sat_clr;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, sample_tick, sat_flag;
  logic [7:0]  leds_meter;

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] sb_q [$];
  logic [15:0] cur_exp;
  logic [15:0] mon_word;
  logic        mon_pad, mon_synced, prev_bclk, prev_lr;
  int          mon_pos;

  bit          sat_model, pend_sat;
  time         t_last;

  always #5 clk_clk = ~clk_clk;

  ks_mix_i2s #(.BCLK_HALF(BH)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .voice0(vin[0]), .voice1(vin[1]), .voice2(vin[2]),
    .voice3(vin[3]), .voice4(vin[4]), .voice5(vin[5]),
    .voice_en(voice_en), .att(att), .sat_clr(sat_clr),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .sample_tick(sample_tick), .sat_flag(sat_flag), .leds_meter(leds_meter)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  // Independent mix model: signed sum of enabled voices, arithmetic shift, clip.
  task automatic model(output logic [15:0] w, output bit s);
    int sum;
    sum = 0;
    for (int i = 0; i < 6; i++)
      if (voice_en[i]) sum += int'($signed(vin[i]));
    sum = sum >>> att;
    s = 1'b0;
    if (sum > 32767)       begin w = 16'h7FFF; s = 1'b1; end
    else if (sum < -32768) begin w = 16'h8000; s = 1'b1; end
    else                   w = 16'(sum);
  endtask

  task automatic push_model();
    logic [15:0] w;
    bit s;
    model(w, s);
    sb_q.push_back(w);
    pend_sat = s;
  endtask

  task automatic apply_stim(input int k);
    case (k)
      0: begin
        for (int i = 0; i < 6; i++) vin[i] = 16'h0000;
        vin[0] = 16'h1234; voice_en = 6'b000001; att = 2'd0;
      end
      1: begin for (int i = 0; i < 6; i++) vin[i] = 16'h7FFF; voice_en = 6'h3F; att = 2'd0; end
      2: begin for (int i = 0; i < 6; i++) vin[i] = 16'h7FFF; voice_en = 6'h3F; att = 2'd3; end
      3: begin for (int i = 0; i < 6; i++) vin[i] = 16'h8000; voice_en = 6'h3F; att = 2'd2; end
      4: begin for (int i = 0; i < 6; i++) vin[i] = 16'h8000; voice_en = 6'h3F; att = 2'd3; end
      5: begin
        for (int i = 0; i < 6; i++) vin[i] = 16'h1111 * 16'(i + 1);
        voice_en = 6'h00; att = 2'd0;
      end
      6, 7: begin
        for (int i = 0; i < 6; i++) vin[i] = 16'($urandom);
        voice_en = 6'($urandom); att = 2'($urandom);
      end
      default: begin
        for (int i = 0; i < 6; i++) vin[i] = 16'(i + 1);
        voice_en = 6'h3F; att = 2'd0;
      end
    endcase
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk_clk);
      n++;
    end while (!sample_tick && n < 3 * FRAME);
    if (!sample_tick) begin
      chk("tick_wait", 32'd0, 32'd1);
      finish_up();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bclk"},  32'(i2s_bclk),    32'd0);
    chk({tag, "_lrclk"}, 32'(i2s_lrclk),   32'd1);
    chk({tag, "_sdata"}, 32'(i2s_sdata),   32'd0);
    chk({tag, "_tick"},  32'(sample_tick), 32'd0);
    chk({tag, "_sat"},   32'(sat_flag),    32'd0);
    chk({tag, "_leds"},  32'(leds_meter),  32'd0);
  endtask

  // I2S receiver: sample at BCLK rising edges, slot position restarts on each lrclk change.
  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      mon_synced = 1'b0;
      prev_bclk  = 1'b0;
      prev_lr    = 1'b1;
      mon_pos    = 0;
    end else begin
      if (i2s_bclk && !prev_bclk) begin
        if (i2s_lrclk != prev_lr) begin
          mon_pos = 0;
          if (!i2s_lrclk) mon_synced = 1'b1;
        end else begin
          mon_pos++;
        end
        prev_lr = i2s_lrclk;
        if (mon_synced) begin
          if (mon_pos == 0) begin
            mon_pad  = i2s_sdata;
            mon_word = '0;
          end else if (mon_pos <= 16) begin
            mon_word = {mon_word[14:0], i2s_sdata};
          end else begin
            mon_pad = mon_pad | i2s_sdata;
          end
          if (mon_pos == 31) begin
            if (!i2s_lrclk) begin
              if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
                cur_exp = '0;
              end else begin
                cur_exp = sb_q.pop_front();
              end
              chk("left_word", 32'(mon_word), 32'(cur_exp));
              chk("left_pad",  32'(mon_pad),  32'd0);
            end else begin
              chk("right_word", 32'(mon_word), 32'(cur_exp));
              chk("right_pad",  32'(mon_pad),  32'd0);
            end
          end
        end
      end
      prev_bclk = i2s_bclk;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sat_clr = 1'b0;
    apply_stim(0);
    repeat (3) @(posedge clk_clk);
    #1 check_reset_outputs("rst");
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    sb_q.delete();
    sb_q.push_back(16'h0000);
    push_model();
    sat_model = 1'b0;
    wait_tick(n);
    chk("first_tick", 32'(n), 32'(2 * BH));
    t_last = $time;

    for (int k = 0; k <= NS; k++) begin
      if (k == 3) begin
        repeat (7) @(posedge clk_clk);
        #1 sat_clr = 1'b1;
        @(posedge clk_clk);
        #1 sat_clr = 1'b0;
        repeat (12) @(posedge clk_clk);
        #1;
      end else begin
        repeat (20) @(posedge clk_clk);
        #1;
      end
      sat_model = sat_model | pend_sat;
      chk("sat_flag", 32'(sat_flag), 32'(sat_model));
      if (k == 1 || k == 3) begin
        sat_clr = 1'b1;
        @(posedge clk_clk);
        #1 sat_clr = 1'b0;
        sat_model = 1'b0;
        chk("sat_clr", 32'(sat_flag), 32'(sat_model));
      end
      if (k + 1 < NS) apply_stim(k + 1);
      push_model();
      wait_tick(n);
      chk("tick_period", 32'(($time - t_last) / 10), 32'(FRAME));
      t_last = $time;
    end

    n = 0;
    do begin
      @(negedge clk_clk);
      #1;
      n++;
    end while (!(mon_synced && !i2s_lrclk && mon_pos == 20) && n < 2 * FRAME);
    chk("reach_bit20", 32'(n < 2 * FRAME), 32'd1);
    #2 reset_reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    sb_q.delete();
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    sb_q.push_back(16'h0000);
    push_model();
    sat_model = 1'b0;
    wait_tick(n);
    chk("first_tick_after_rst", 32'(n), 32'(2 * BH));
    t_last = $time;
    for (int k = 0; k < 3; k++) begin
      push_model();
      wait_tick(n);
      chk("tick_period_after_rst", 32'(($time - t_last) / 10), 32'(FRAME));
      t_last = $time;
    end
    repeat (FRAME / 2) @(posedge clk_clk);
    finish_up();
  end

endmodule

// File: doc/ks_mix_i2s.md
# ks_mix_i2s

Downstream audio stage for the six Karplus-Strong voice exports of the Nios system. Samples the six 16-bit signed voice words once per audio frame, sums the enabled voices with programmable attenuation and saturation, and transmits the mono result on both channels of an I2S master stream (BCLK, LRCLK, SDATA) toward the board codec/DAC. Emits a per-frame tick for software/voice pacing and a sticky clip flag.

## Interface

- BCLK_HALF, 8: clk cycles per BCLK half-period; legal ≥4. With a 50 MHz clk this gives BCLK 3.125 MHz and a 48.8 kHz frame rate.
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- voice0 … voice5  in  16 each  signed two's-complement voice samples, taken from karplus_strong_0..5_export.
- voice_en  in  6  per-voice enable; bit i gates voice i.
- att  in  2  attenuation; arithmetic right shift of the sum by 0..3.
- sat_clr  in  1  one-cycle pulse that clears sat_flag.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first.
- sample_tick  out  1  one-clk pulse at each frame start.
- sat_flag  out  1  sticky; set when any mix result clipped.
- leds_meter  out  8  level meter; see Configuration.

## Operation

- Divider: counter 0..BCLK_HALF-1; i2s_bclk toggles when the counter wraps. A falling edge of i2s_bclk is the clk cycle in which bclk goes 1→0.
- bit_cnt is 6 bits, resets to 63, and increments on every BCLK falling edge. Wrap to 0 is the frame start. A frame is 64 BCLK.
- i2s_lrclk equals bit_cnt[5] and updates on the same falling edge as bit_cnt.
- Slot position p = bit_cnt[4:0]:
  - p=0: sdata=0 (I2S one-bit delay).
  - p=1..16: sdata = tx_word[16-p].
  - p=17..31: sdata=0.
- Left and right carry the same tx_word.
- At frame start, in the same cycle:
  - tx_word ← mix_reg.
  - sample_tick=1.
  - The mixer FSM leaves IDLE.
- Mixer FSM:
  - IDLE → CAP: latch voice0..5 and voice_en into snapshot registers; acc ← 0.
  - CAP → ACC: six cycles, idx 0..5. acc ← acc + (en[idx] ? sext(v[idx]) : 0). acc is 19-bit signed and never overflows.
  - ACC → SAT: s = acc >>> att. If s > 32767, mix_reg ← 0x7FFF and sat_flag ← 1. If s < −32768, mix_reg ← 0x8000 and sat_flag ← 1. Otherwise mix_reg ← s[15:0].
  - SAT → IDLE.
  - The FSM completes in 9 clk, far less than one frame, so it never overlaps the next frame start.
- sat_flag: sat_clr clears it. If a set and sat_clr occur in the same cycle, the set wins.
- Voice inputs are async-stable PIO registers. Only the snapshot taken in CAP is used, so changes mid-frame do not affect the current mix.

## Timing

- Reset values: i2s_bclk=0, i2s_lrclk=1 (bit_cnt=63), i2s_sdata=0, sample_tick=0, sat_flag=0, leds_meter=0, mix_reg=0, tx_word=0, FSM=IDLE.
- Reset asserted mid-frame forces all of the above immediately. It is asynchronous and does not wait for a clock edge.
- First BCLK falling edge after reset release (2·BCLK_HALF clk) is frame 0. Frame 0 transmits 0x0000.
- Latency: voices captured at frame n are transmitted in frame n+1.
  - MSB appears on sdata at the BCLK falling edge with p=1, i.e. 1 BCLK after the frame-n+1 start.
- sample_tick period is exactly 128·BCLK_HALF clk.
- sdata and lrclk change only on BCLK falling edges, so they are stable at BCLK rising edges.

## Configuration

- KS_MIX_METER_EN defined:
  - leds_meter[k] = 1 when |mix_reg| ≥ 2^(7+k), k=0..7, with |0x8000| treated as 32768.
  - Updated in the cycle after SAT.
  - Peak hold: a lit bit stays lit for at least 16 frames after its last qualifying result.
- KS_MIX_METER_EN undefined: the leds_meter port is present and held at 0. No meter logic is synthesized.

## Test plan

- Reset → bclk=0, lrclk=1, sdata=0, sat_flag=0. Frame 0 transmits all zeros. The first sample_tick occurs 2·BCLK_HALF clk after release.
- voice0=0x1234, others 0, voice_en=6'b000001, att=0 → next frame's left and right words = 0x1234 with MSB at p=1 and zeros at p=0 and p=17..31. sample_tick period = 1024 clk. With KS_MIX_METER_EN, leds_meter=0x3F.
- All voices 0x7FFF, voice_en=6'h3F:
  - att=0 → word 0x7FFF, sat_flag=1.
  - att=3 → word 0x5FFF (24575), no new saturation.
- All voices 0x8000, voice_en=6'h3F:
  - att=2 → 0x8000 with sat.
  - att=3 → 0xA000 (−24576), no sat.
- voice_en=0 with nonzero voices → word 0x0000. sat_clr pulsed in the same cycle a saturating SAT occurs → sat_flag remains 1.
- Reset asserted at bit_cnt=20 mid-word → outputs return to reset values within the same cycle. After release, the stream restarts at frame 0 transmitting zeros.
